// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between the requesters (master) and the round-robin arbiter (slave).
// All arbiter outputs are registered. state_dbg is high while a grant is held.
interface rr_arbiter_4_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] gnt_id;
    logic       timeout;
    logic       state_dbg;

    // Handshake: req is level-sensitive and must stay high for as long as the owner wants the grant.
    // Dropping req[gnt_id] releases the grant one cycle later. A new grant always follows an all-zero gnt cycle.
    modport master (output req, input gnt, input gnt_valid, input gnt_id, input timeout, input state_dbg);
    modport slave  (input req, output gnt, output gnt_valid, output gnt_id, output timeout, output state_dbg);
endinterface

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with hold-until-release and an optional hold timeout.
// The one-hot gnt feeds a 4-to-2 encoder, so it is only ever one-hot or all-zero.
module rr_arbiter_4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          rst,
    rr_arbiter_4_if.slave bus
);

    localparam int unsigned HW_RAW  = $clog2(MAX_HOLD + 1);
    localparam int unsigned HW      = (HW_RAW < 1) ? 1 : HW_RAW;
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
    localparam bit LIMITED = (MAX_HOLD != 0);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [1:0]    last_q, last_d;
    logic [HW-1:0] cnt_q, cnt_d;
    logic [3:0]    gnt_q, gnt_d;
    logic [1:0]    id_q, id_d;
    logic          valid_q, valid_d;
    logic          to_q, to_d;

    logic [1:0]    win;
    logic          win_found;
    logic [1:0]    cand;

    // Scan last+1 .. last+4 (mod 4); the first requester found wins.
    always_comb begin
        win       = last_q;
        win_found = 1'b0;
        cand      = last_q;
        for (int k = 1; k <= 4; k++) begin
            cand = last_q + 2'(k);
            if (!win_found && bus.req[cand]) begin
                win       = cand;
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        valid_d = valid_q;
        to_d    = 1'b0;
        case (state_q)
            IDLE: begin
                gnt_d   = 4'b0000;
                id_d    = 2'd0;
                valid_d = 1'b0;
                if (win_found) begin
                    state_d = GRANT;
                    last_d  = win;
                    cnt_d   = HW'(1);
                    gnt_d   = 4'b0001 << win;
                    id_d    = win;
                    valid_d = 1'b1;
                end
            end
            GRANT: begin
                // Release wins over timeout; either way the next cycle is an all-zero gap.
                if (!bus.req[id_q]) begin
                    state_d = IDLE;
                    gnt_d   = 4'b0000;
                    id_d    = 2'd0;
                    valid_d = 1'b0;
                end else if (LIMITED && cnt_q == HOLD_MAX) begin
                    state_d = IDLE;
                    gnt_d   = 4'b0000;
                    id_d    = 2'd0;
                    valid_d = 1'b0;
                    to_d    = 1'b1;
                end else if (LIMITED && cnt_q != HOLD_MAX) begin
                    cnt_d = cnt_q + HW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 2'd3;
            cnt_q   <= '0;
            gnt_q   <= 4'b0000;
            id_q    <= 2'd0;
            valid_q <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            valid_q <= valid_d;
            to_q    <= to_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = id_q;
    assign bus.gnt_valid = valid_q;
    assign bus.timeout   = to_q;
    assign bus.state_dbg = (state_q == GRANT);

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Bench for rr_arbiter_4: three instances (MAX_HOLD 8, 4, 0) share one stimulus and are
// checked every cycle against a queue-free owner/last model, plus directed literal sequences.
module tb_rr_arbiter_4;

    // ---------------- clock / reset ----------------
    logic       clk;
    logic       rst;
    logic [3:0] req_drv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    rr_arbiter_4_if if0 ();
    rr_arbiter_4_if if1 ();
    rr_arbiter_4_if if2 ();

    assign if0.req = req_drv;
    assign if1.req = req_drv;
    assign if2.req = req_drv;

    rr_arbiter_4 #(.MAX_HOLD(8)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
    rr_arbiter_4 #(.MAX_HOLD(4)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
    rr_arbiter_4 #(.MAX_HOLD(0)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));

    logic [3:0] gnt_o   [3];
    logic [1:0] id_o    [3];
    logic       valid_o [3];
    logic       to_o    [3];
    logic       st_o    [3];

    assign gnt_o[0] = if0.gnt;  assign id_o[0] = if0.gnt_id;  assign valid_o[0] = if0.gnt_valid;
    assign gnt_o[1] = if1.gnt;  assign id_o[1] = if1.gnt_id;  assign valid_o[1] = if1.gnt_valid;
    assign gnt_o[2] = if2.gnt;  assign id_o[2] = if2.gnt_id;  assign valid_o[2] = if2.gnt_valid;
    assign to_o[0]  = if0.timeout;  assign st_o[0] = if0.state_dbg;
    assign to_o[1]  = if1.timeout;  assign st_o[1] = if1.state_dbg;
    assign to_o[2]  = if2.timeout;  assign st_o[2] = if2.state_dbg;

    // ---------------- scoreboard counters ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // owner = -1 when idle; held = cycles the owner has held the grant so far.
    int mh       [3] = '{8, 4, 0};
    int m_owner  [3];
    int m_held   [3];
    int m_last   [3];
    bit m_to     [3];
    bit model_live = 1'b0;

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                m_owner[d] = -1;
                m_last[d]  = 3;
                m_held[d]  = 0;
                m_to[d]    = 1'b0;
            end else if (m_owner[d] < 0) begin
                m_to[d] = 1'b0;
                for (int k = 1; k <= 4; k++) begin
                    int c;
                    c = (m_last[d] + k) % 4;
                    if (m_owner[d] < 0 && req_drv[c]) m_owner[d] = c;
                end
                if (m_owner[d] >= 0) begin
                    m_last[d] = m_owner[d];
                    m_held[d] = 1;
                end
            end else if (!req_drv[m_owner[d]]) begin
                m_owner[d] = -1;
                m_to[d]    = 1'b0;
            end else if (mh[d] != 0 && m_held[d] == mh[d]) begin
                m_owner[d] = -1;
                m_to[d]    = 1'b1;
            end else begin
                m_to[d] = 1'b0;
                if (mh[d] != 0) m_held[d] = m_held[d] + 1;
            end
        end
        if (rst) model_live = 1'b1;
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (model_live) begin
            for (int d = 0; d < 3; d++) begin
                logic [3:0] eg;
                logic [3:0] one;
                one = 4'b0001;
                eg  = (m_owner[d] < 0) ? 4'b0000 : (one << m_owner[d]);
                check($sformatf("u%0d.gnt", d),       32'(gnt_o[d]),   32'(eg));
                check($sformatf("u%0d.gnt_id", d),    32'(id_o[d]),    (m_owner[d] < 0) ? 32'd0 : 32'(m_owner[d]));
                check($sformatf("u%0d.gnt_valid", d), 32'(valid_o[d]), 32'(m_owner[d] >= 0));
                check($sformatf("u%0d.timeout", d),   32'(to_o[d]),    32'(m_to[d]));
                check($sformatf("u%0d.state", d),     32'(st_o[d]),    32'(m_owner[d] >= 0));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [3:0] r);
        rst     = 1'b1;
        req_drv = r;
        tick();
        rst     = 1'b0;
    endtask

    // ---------------- directed + random stimulus ----------------
    logic [3:0] exp_q[$];

    initial begin
        rst     = 1'b1;
        req_drv = 4'b1111;

        // Reset held 3 cycles with all requests up: outputs stay zero, then requester 0 wins.
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_gnt", 32'(gnt_o[0]), 32'd0);
            check("rst_valid", 32'(valid_o[0]), 32'd0);
            check("rst_timeout", 32'(to_o[0]), 32'd0);
        end
        rst = 1'b0;
        tick();
        check("post_rst_gnt", 32'(gnt_o[0]), 32'h1);
        check("post_rst_id", 32'(id_o[0]), 32'd0);

        // MAX_HOLD=4 with req=0011 constant: 0,0,0,0,to,1,1,1,1,to,0.
        do_reset(4'b0011);
        exp_q = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
                  4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0001};
        for (int c = 0; c < 11; c++) begin
            tick();
            check("to_seq_gnt", 32'(gnt_o[1]), 32'(exp_q[c]));
            check("to_seq_timeout", 32'(to_o[1]), (c == 4 || c == 9) ? 32'd1 : 32'd0);
        end

        // Round robin: each owner drops its request for one cycle after two grant cycles.
        do_reset(4'b1111);
        exp_q = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
                  4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
        for (int c = 0; c < 13; c++) begin
            logic [3:0] one;
            one = 4'b0001;
            tick();
            check("rr_gnt", 32'(gnt_o[0]), 32'(exp_q[c]));
            if (c % 3 == 1) req_drv = 4'b1111 & ~(one << ((c / 3) % 4));
            else            req_drv = 4'b1111;
        end

        // Single requester 2 for five cycles, then released.
        do_reset(4'b0000);
        req_drv = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("single_gnt", 32'(gnt_o[0]), 32'h4);
            check("single_id", 32'(id_o[0]), 32'd2);
        end
        req_drv = 4'b0000;
        tick();
        check("single_release", 32'(gnt_o[0]), 32'd0);

        // Unlimited hold on the MAX_HOLD=0 instance.
        do_reset(4'b1000);
        for (int c = 0; c < 300; c++) begin
            tick();
            check("unlim_gnt", 32'(gnt_o[2]), 32'h8);
            check("unlim_timeout", 32'(to_o[2]), 32'd0);
        end

        // Reset mid-grant restores last=3, so index 2 wins over 3.
        do_reset(4'b0100);
        tick();
        check("midrst_pre", 32'(gnt_o[0]), 32'h4);
        rst     = 1'b1;
        req_drv = 4'b1100;
        tick();
        check("midrst_zero", 32'(gnt_o[0]), 32'd0);
        rst = 1'b0;
        tick();
        check("midrst_regrant", 32'(gnt_o[0]), 32'h4);
        check("midrst_id", 32'(id_o[0]), 32'd2);

        // Randomized traffic; long holds are common so timeouts fire on both limited instances.
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 99) < 15) req_drv = 4'($urandom_range(0, 15));
        end
        rst = 1'b0;
        for (int c = 0; c < 4; c++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
